// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window controller.
// Window lanes Z1..Z9 are byte indices into the packed 3x3 window, row-major.
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_W = 9 * PIX_W;

    localparam int Z1 = 0;
    localparam int Z2 = 1;
    localparam int Z3 = 2;
    localparam int Z4 = 3;
    localparam int Z5 = 4;
    localparam int Z6 = 5;
    localparam int Z7 = 6;
    localparam int Z8 = 7;
    localparam int Z9 = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sobel_state_t;

    // One image column of the window: top is row-2, bot is the current row.
    typedef struct packed {
        logic [PIX_W-1:0] bot;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] top;
    } win_col_t;

    function automatic logic [PIX_W-1:0] win_lane(input logic [WIN_W-1:0] w, input int z);
        return w[z*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-in / edge-out stream bundle of the Sobel window controller.
// master = frame reader plus edge-map sink, slave = the controller.
interface sobel_window_ctrl_if;
    import sobel_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    logic             out_last;

    modport master (
        output in_valid,
        output in_pixel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_pixel,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_pixel,
        output out_last
    );

endinterface

// File: rtl/sobel_line_buf.sv
// Two-row line buffer: returns rows r-2 and r-1 at column col, shifts in the new pixel.
// Latency: combinational read, write on the accept edge (read-before-write).
// Backpressure: none of its own; only moves when the controller accepts a pixel.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic [CW-1:0]    col,
    input  logic             acc,
    input  logic [PIX_W-1:0] wr_pixel,
    output logic [PIX_W-1:0] rd_row2,
    output logic [PIX_W-1:0] rd_row1
);

    logic [PIX_W-1:0] mem_r2 [IMG_W];
    logic [PIX_W-1:0] mem_r1 [IMG_W];

    assign rd_row2 = mem_r2[col];
    assign rd_row1 = mem_r1[col];

    // Contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem_r2[col] <= mem_r1[col];
            mem_r1[col] <= wr_pixel;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequences a raster image through a 3x3 Sobel datapath; SOBEL_THRESH_EN adds binary thresholding.
// Latency: pixel accepted at t -> win_valid at t+1 -> out_valid at t+2.
// Backpressure: out_valid & !out_ready freezes win and output stage and drops in_ready.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    sobel_window_ctrl_if.slave px,
    output logic [WIN_W-1:0]  win,
    output logic              win_valid,
    input  logic [PIX_W-1:0]  edge_in
`ifdef SOBEL_THRESH_EN
    ,
    input  logic [PIX_W-1:0]  thresh
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    sobel_state_t     state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             all_rx;
    logic             win_last;
    logic             adv;
    logic             acc;
    logic             interior;
    logic             last_pix;
    logic             out_hs_last;
    logic [PIX_W-1:0] tap2;
    logic [PIX_W-1:0] tap1;
    logic [PIX_W-1:0] edge_val;
    win_col_t         col_m2;
    win_col_t         col_m1;
    win_col_t         new_col;
    logic [WIN_W-1:0] win_next;

    assign adv         = !px.out_valid || px.out_ready;
    assign px.in_ready = ((state == FILL) || (state == RUN)) && adv && !all_rx;
    assign acc         = px.in_valid && px.in_ready;
    assign interior    = (row >= RW'(2)) && (col >= CW'(2));
    assign last_pix    = (col == COL_LAST) && (row == ROW_LAST);
    assign out_hs_last = px.out_valid && px.out_ready && px.out_last;

    sobel_line_buf #(
        .IMG_W (IMG_W),
        .CW    (CW)
    ) u_line_buf (
        .clk      (clk),
        .col      (col),
        .acc      (acc),
        .wr_pixel (px.in_pixel),
        .rd_row2  (tap2),
        .rd_row1  (tap1)
    );

    assign new_col = '{bot: px.in_pixel, mid: tap1, top: tap2};

    always_comb begin
        win_next = '0;
        win_next[Z1*PIX_W +: PIX_W] = col_m2.top;
        win_next[Z2*PIX_W +: PIX_W] = col_m1.top;
        win_next[Z3*PIX_W +: PIX_W] = new_col.top;
        win_next[Z4*PIX_W +: PIX_W] = col_m2.mid;
        win_next[Z5*PIX_W +: PIX_W] = col_m1.mid;
        win_next[Z6*PIX_W +: PIX_W] = new_col.mid;
        win_next[Z7*PIX_W +: PIX_W] = col_m2.bot;
        win_next[Z8*PIX_W +: PIX_W] = col_m1.bot;
        win_next[Z9*PIX_W +: PIX_W] = new_col.bot;
    end

`ifdef SOBEL_THRESH_EN
    assign edge_val = (edge_in >= thresh) ? {PIX_W{1'b1}} : '0;
`else
    assign edge_val = edge_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            col    <= '0;
            row    <= '0;
            all_rx <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= FILL;
                        busy   <= 1'b1;
                        col    <= '0;
                        row    <= '0;
                        all_rx <= 1'b0;
                    end
                end
                FILL, RUN: begin
                    if (acc) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_pix) begin
                            all_rx <= 1'b1;
                        end
                        if ((state == FILL) && interior) begin
                            state <= RUN;
                        end
                    end
                    // The frame ends on the sink's acceptance, not on the last input pixel.
                    if (out_hs_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_m2       <= '0;
            col_m1       <= '0;
            win          <= '0;
            win_valid    <= 1'b0;
            win_last     <= 1'b0;
            px.out_valid <= 1'b0;
            px.out_pixel <= '0;
            px.out_last  <= 1'b0;
        end else begin
            // Border pixels still shift through so the next interior window is complete.
            if (acc) begin
                col_m2 <= col_m1;
                col_m1 <= new_col;
            end
            if (adv) begin
                win_valid <= acc && interior;
                win_last  <= acc && last_pix;
                if (acc && interior) begin
                    win <= win_next;
                end
                px.out_valid <= win_valid;
                px.out_last  <= win_valid && win_last;
                if (win_valid) begin
                    px.out_pixel <= edge_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 4x4 frame with a behavioural Sobel datapath.
// Expected pixel values are hand-derived for the constant and column-step frames.
module tb_sobel_window_ctrl;
    import sobel_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int NOUT = (W - 2) * (H - 2);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIN_W-1:0] win;
    logic             win_valid;
    logic [7:0]       edge_in;
`ifdef SOBEL_THRESH_EN
    logic [7:0]       thresh;
`endif

    sobel_window_ctrl_if px();

    always #5 clk = ~clk;

    sobel_window_ctrl #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .px        (px),
        .win       (win),
        .win_valid (win_valid),
        .edge_in   (edge_in)
`ifdef SOBEL_THRESH_EN
        ,
        .thresh    (thresh)
`endif
    );

    // Sobel datapath stand-in: |gx|,|gy| saturated to 255, magnitude = (gx+gy)/2.
    function automatic logic [7:0] sobel_mag(input logic [WIN_W-1:0] w);
        int z [9];
        int gx;
        int gy;
        for (int k = 0; k < 9; k++) z[k] = int'(win_lane(w, k));
        gx = (z[Z3] + 2*z[Z6] + z[Z9]) - (z[Z1] + 2*z[Z4] + z[Z7]);
        gy = (z[Z7] + 2*z[Z8] + z[Z9]) - (z[Z1] + 2*z[Z2] + z[Z3]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        if (gx > 255) gx = 255;
        if (gy > 255) gy = 255;
        return 8'((gx + gy) >> 1);
    endfunction

    assign edge_in = sobel_mag(win);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int pat, input int c);
        if (pat == 0) return 8'd100;
        return (c < 2) ? 8'd0 : 8'd255;
    endfunction

    function automatic logic [7:0] exp_px(input logic [7:0] raw);
`ifdef SOBEL_THRESH_EN
        return (raw >= thresh) ? 8'd255 : 8'd0;
`else
        return raw;
`endif
    endfunction

    int         cyc = 0;
    logic [7:0] outq [$];
    bit         lastq [$];
    int         wv_cnt;
    int         done_cnt;
    int         last_hs_cyc;
    int         done_cyc;
    int         first_ov_cyc;
    int         acc10_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (px.out_valid && px.out_ready) begin
            outq.push_back(px.out_pixel);
            lastq.push_back(px.out_last);
            if (px.out_last) last_hs_cyc = cyc;
        end
        if (px.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (win_valid) wv_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic mon_clear();
        outq.delete();
        lastq.delete();
        wv_cnt       = 0;
        done_cnt     = 0;
        last_hs_cyc  = -100;
        done_cyc     = -1;
        first_ov_cyc = -1;
        acc10_cyc    = -100;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_frame(input int pat, input bit gaps, input int npix);
        for (int i = 0; i < npix; i++) begin
            int n;
            n = 0;
            if (gaps) begin
                px.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            px.in_valid = 1'b1;
            px.in_pixel = pix_of(pat, i % W);
            forever begin
                @(negedge clk);
                if (px.in_ready) begin
                    if (i == 2*W + 2) acc10_cyc = cyc;
                    @(posedge clk); #1;
                    break;
                end
                n++;
                if (n > 200) begin
                    check("accept_timeout", 32'(px.in_ready), 1);
                    break;
                end
            end
        end
        px.in_valid = 1'b0;
    endtask

    task automatic sink(input bit stall);
        logic [7:0]       held;
        logic [WIN_W-1:0] held_win;
        int               n;
        if (!stall) begin
            px.out_ready = 1'b1;
            return;
        end
        px.out_ready = 1'b0;
        n = 0;
        while (!px.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        held     = px.out_pixel;
        held_win = win;
        repeat (5) begin
            @(negedge clk);
            check("stall_pixel", 32'(px.out_pixel), 32'(held));
            check("stall_in_ready", 32'(px.in_ready), 0);
            check("stall_win", 32'(win == held_win), 1);
        end
        @(posedge clk); #1;
        px.out_ready = 1'b1;
    endtask

    task automatic poke_start(input bit poke, input string tag);
        if (!poke) return;
        repeat (24) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_mid"}, 32'(busy), 1);
    endtask

    task automatic run_frame(input string tag, input int pat, input bit gaps,
                             input bit stall, input bit poke, input logic [7:0] raw);
        int n;
        mon_clear();
        px.out_ready = 1'b1;
        start_frame();
        fork
            drive_frame(pat, gaps, W*H);
            sink(stall);
            poke_start(poke, tag);
        join
        n = 0;
        while (done_cnt == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_count"}, 32'(outq.size()), NOUT);
        foreach (outq[i]) begin
            check({tag, "_pixel"}, 32'(outq[i]), 32'(exp_px(raw)));
            check({tag, "_last"}, 32'(lastq[i]), 32'(i == NOUT - 1));
        end
        check({tag, "_done_gap"}, done_cyc - last_hs_cyc, 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_latency"}, first_ov_cyc - acc10_cyc, 2);
        if (!stall) check({tag, "_win_valid_cnt"}, wv_cnt, NOUT);
        check({tag, "_busy_end"}, 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        px.in_valid  = 1'b0;
        px.in_pixel  = '0;
        px.out_ready = 1'b0;
`ifdef SOBEL_THRESH_EN
        thresh       = 8'd0;
`endif
        mon_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_in_ready", 32'(px.in_ready), 0);
        check("rst_win_valid", 32'(win_valid), 0);
        check("rst_out_valid", 32'(px.out_valid), 0);
        check("rst_out_pixel", 32'(px.out_pixel), 0);
        check("rst_out_last", 32'(px.out_last), 0);
        check("rst_win_zero", 32'(win == '0), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame("const", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        run_frame("step",  1, 1'b0, 1'b0, 1'b0, 8'd127);
        run_frame("stall", 1, 1'b0, 1'b1, 1'b0, 8'd127);
        run_frame("gaps",  1, 1'b1, 1'b0, 1'b1, 8'd127);

        // Abandon a frame in RUN with a synchronous reset.
        mon_clear();
        px.out_ready = 1'b1;
        start_frame();
        drive_frame(1, 1'b0, 12);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_out_valid", 32'(px.out_valid), 0);
        check("abort_in_ready", 32'(px.in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        @(posedge clk); #1;

        run_frame("restart", 1, 1'b0, 1'b0, 1'b0, 8'd127);

`ifdef SOBEL_THRESH_EN
        thresh = 8'd128;
        run_frame("thr128", 1, 1'b0, 1'b0, 1'b0, 8'd127);
        check("thr128_value", 32'(outq.size() > 0 ? outq[0] : 8'hAA), 0);
        thresh = 8'd127;
        run_frame("thr127", 1, 1'b0, 1'b0, 1'b0, 8'd127);
        check("thr127_value", 32'(outq.size() > 0 ? outq[0] : 8'hAA), 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
Streaming controller that sequences the combinational 3x3 Sobel magnitude datapath over a raster-order image. It accepts one 8-bit pixel per handshake and keeps two line buffers plus a 3x3 shift window. It presents each interior window to the Sobel datapath, registers the returned edge magnitude, and emits it on a valid/ready output stream with frame framing. It sits between the pixel source (frame reader) and the edge-map sink.

Parameters:
IMG_W, 64, pixels per row (>=3)
IMG_H, 64, rows per frame (>=3)
PIX_W, 8, pixel width (fixed at 8 for the current Sobel datapath)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; starts a frame when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last output handshake
in_valid  in  1  input pixel valid
in_ready  out  1  controller accepts pixel
in_pixel  in  8  raster-order pixel
win  out  72  window to Sobel: win[7:0]=z1 (top-left) … win[71:64]=z9 (bottom-right), row-major
win_valid  out  1  win holds an interior window
edge_in  in  8  Sobel z_out for the current win (combinational return)
out_valid  out  1  output pixel valid
out_ready  in  1  sink accepts output
out_pixel  out  8  edge magnitude
out_last  out  1  qualifies final output pixel of the frame

Behaviour:
- Reset: all outputs 0; busy=0, done=0, in_ready=0, win_valid=0, out_valid=0; counters 0; state IDLE. Reset mid-frame abandons the frame with no done pulse. Line-buffer contents are don't-care.
- FSM states:
  - IDLE: start → FILL; col=row=0. start is ignored in every other state.
  - FILL: rows 0-1 and the first two pixels of row 2 enter the line buffers; no windows issued. Transition to RUN when the pixel with row>=2 and col>=2 is accepted.
  - RUN: each accepted pixel with col>=2 (row>=2) loads win and sets win_valid. Pixels with col<2 only shift the window. After the out handshake of pixel (IMG_W-1, IMG_H-1) → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Counters: col wraps IMG_W-1→0 and increments row. Widths are $clog2 of IMG_W/IMG_H.
- Pipeline: adv = !out_valid | out_ready.
  - in_ready = (state in FILL, RUN) & adv & !all_pixels_received.
  - win register and out register update only on adv.
  - out register loads edge_in when win_valid & adv.
  - Latency: pixel accepted at cycle t → win_valid at t+1 → out_valid at t+2 (no stalls).
- Output count is exactly (IMG_W-2)*(IMG_H-2) per frame; there is no border output.
- out_last=1 only with the final out_valid.
- Stall: while out_valid & !out_ready, out_pixel, out_last, win and win_valid hold stable, and in_ready=0.
- in_valid low: bubbles; win_valid drops on the next adv.
- Line buffers: two IMG_W×8 memories, read and write at the same col on each accept (read-before-write).

Optional Feature:
Macro SOBEL_THRESH_EN.
- Defined: adds port thresh (in, 8). The out register loads (edge_in >= thresh) ? 8'd255 : 8'd0.
- Undefined: no thresh port; the raw magnitude passes through. Timing is identical in both cases.

Decomposition:
- Package sobel_pkg holds:
  - PIX_W
  - window index constants Z1..Z9 (byte lanes 0..8)
  - FSM enum {IDLE, FILL, RUN, DONE}
- Sub-module sobel_line_buf: two-row buffer with a col address, accept strobe, and two-tap read (row-2, row-1). The controller owns counters, window shift registers, FSM and output stage.

Test Plan (IMG_W=IMG_H=4 unless noted):
- Constant frame, all pixels 100, out_ready=1 → 4 outputs of 0; out_last on 4th; done pulses one cycle after it.
- Columns 0,0,255,255 in every row → 4 outputs of 127 (gx saturated to 255, gy=0); first out_valid exactly 2 cycles after pixel (2,2) is accepted.
- Same frame with out_ready low for 5 cycles after the first out_valid → out_pixel held, in_ready=0 during the stall, no lost or duplicated outputs, still 4 total.
- in_valid toggled every other cycle → same 4 values in order; win_valid pulses only on interior pixels.
- start pulsed during RUN → ignored. rst asserted mid-RUN → next cycle busy=0, out_valid=0, in_ready=0; a fresh start then yields a correct full frame.
- SOBEL_THRESH_EN defined, thresh=128, column-step frame → outputs 0 (127<128); thresh=127 → outputs 255.
